// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: sequences the NS/EW vehicle heads and the pedestrian
// walk lamp from the upstream 2-bit traffic mode (00 day, 01 night, 10 ped, 11 emg).
// Timed phases count `tick` pulses. Emergency preemption does not wait for a tick.
// Build option PED_REQ_LATCH_EN: when it is defined, a pedestrian request is held
// in a sticky latch. When it is not defined, a request counts only while mode is 10.
`timescale 1ns/1ps
module traffic_phase_sequencer #(
    parameter int CNT_W    = 6,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] mode,
    output logic [2:0] nsLight,
    output logic [2:0] ewLight,
    output logic       walk,
    output logic [3:0] phase,
    output logic       pedPending
);

    typedef enum logic [3:0] {
        NS_G  = 4'd0,
        NS_Y  = 4'd1,
        RED_A = 4'd2,
        EW_G  = 4'd3,
        EW_Y  = 4'd4,
        RED_B = 4'd5,
        WALK  = 4'd6,
        EMG   = 4'd7,
        FLASH = 4'd8
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  timer, load_val;
    logic              flash;
    logic              ret_ew, ret_ew_nx;
    logic              emg, night, done;

    // A duration of 0 is treated as 1, so the timer is loaded with 0 in both cases.
    function automatic logic [CNT_W-1:0] dur_m1(input int d);
        return (d <= 1) ? '0 : CNT_W'(d - 1);
    endfunction

    assign emg   = (mode == 2'b11);
    assign night = (mode == 2'b01);
    assign done  = tick && (timer == '0);

`ifdef PED_REQ_LATCH_EN
    logic ped_q;

    // Sticky request: set by mode 10, cleared on entry to WALK or by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ped_q <= 1'b0;
        else if (state_nx == WALK && state != WALK)
            ped_q <= 1'b0;
        else if (mode == 2'b10)
            ped_q <= 1'b1;
    end

    assign pedPending = ped_q;
`else
    assign pedPending = (mode == 2'b10);
`endif

    // Next-state decision. Priority: emergency, then pending pedestrian, then night, then day.
    always_comb begin
        state_nx  = state;
        ret_ew_nx = ret_ew;
        case (state)
            NS_G:  if (emg || done) state_nx = NS_Y;
            NS_Y:  if (done) state_nx = emg ? EMG : RED_A;
            RED_A: begin
                if (emg)
                    state_nx = EMG;
                else if (done) begin
                    if (pedPending) begin
                        state_nx  = WALK;
                        ret_ew_nx = 1'b1;
                    end else if (night)
                        state_nx = FLASH;
                    else
                        state_nx = EW_G;
                end
            end
            EW_G:  if (emg || done) state_nx = EW_Y;
            EW_Y:  if (done) state_nx = emg ? EMG : RED_B;
            RED_B: begin
                if (emg)
                    state_nx = EMG;
                else if (done) begin
                    if (pedPending) begin
                        state_nx  = WALK;
                        ret_ew_nx = 1'b0;
                    end else if (night)
                        state_nx = FLASH;
                    else
                        state_nx = NS_G;
                end
            end
            WALK: begin
                if (emg)
                    state_nx = EMG;
                else if (done)
                    state_nx = ret_ew ? EW_G : NS_G;
            end
            EMG:   if (!emg) state_nx = RED_B;
            FLASH: begin
                if (emg)
                    state_nx = EMG;
                else if (!night)
                    state_nx = RED_B;
            end
            default: state_nx = RED_B;
        endcase
    end

    // Duration of the state being entered. Untimed states load 0.
    always_comb begin
        load_val = '0;
        case (state_nx)
            NS_G, EW_G:   load_val = dur_m1(GREEN_T);
            NS_Y, EW_Y:   load_val = dur_m1(YELLOW_T);
            RED_A, RED_B: load_val = dur_m1(ALLRED_T);
            WALK:         load_val = dur_m1(WALK_T);
            default:      load_val = '0;
        endcase
    end

    // State register and the return flag used to leave WALK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RED_B;
            ret_ew <= 1'b0;
        end else begin
            state  <= state_nx;
            ret_ew <= ret_ew_nx;
        end
    end

    // Phase timer: reloads on every state change and counts down on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= dur_m1(ALLRED_T);
        else if (state_nx != state)
            timer <= load_val;
        else if (tick && timer != '0)
            timer <= timer - CNT_W'(1);
    end

    // Flash phase bit: set on entry to FLASH and toggled on each tick while in FLASH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash <= 1'b0;
        else if (state_nx != FLASH)
            flash <= 1'b0;
        else if (state != FLASH)
            flash <= 1'b1;
        else if (tick)
            flash <= ~flash;
    end

    // Lamp decode from the registered state only. Every head is red unless the state overrides it.
    always_comb begin
        nsLight = 3'b100;
        ewLight = 3'b100;
        walk    = 1'b0;
        case (state)
            NS_G:  nsLight = 3'b001;
            NS_Y:  nsLight = 3'b010;
            EW_G:  ewLight = 3'b001;
            EW_Y:  ewLight = 3'b010;
            WALK:  walk    = 1'b1;
            FLASH: begin
                nsLight = flash ? 3'b010 : 3'b000;
                ewLight = flash ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer. The stimulus side queues the expected
// lamp/phase tuples along with the tick count each one should last. A separate monitor
// pops one tuple each time the visible outputs change and compares it with the DUT.
`timescale 1ns/1ps
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] mode;
    logic [2:0] nsLight, ewLight;
    logic       walk;
    logic [3:0] phase;
    logic       pedPending;

    traffic_phase_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode),
        .nsLight(nsLight), .ewLight(ewLight), .walk(walk),
        .phase(phase), .pedPending(pedPending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] ph;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic       pd;
        int         dwell;   // ticks spent in this output tuple; -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef PED_REQ_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    task automatic push_raw(input string name, input logic [3:0] ph, input logic [2:0] ns,
                            input logic [2:0] ew, input logic wk, input logic pd, input int dwell);
        exp_t e;
        e.name = name; e.ph = ph; e.ns = ns; e.ew = ew; e.wk = wk; e.pd = pd; e.dwell = dwell;
        exp_q.push_back(e);
    endtask

    // Lamp table for non-flash phases.
    task automatic push(input string name, input logic [3:0] ph, input logic pd, input int dwell);
        logic [2:0] ns = 3'b100;
        logic [2:0] ew = 3'b100;
        logic       wk = 1'b0;
        case (ph)
            4'd0: ns = 3'b001;
            4'd1: ns = 3'b010;
            4'd3: ew = 3'b001;
            4'd4: ew = 3'b010;
            4'd6: wk = 1'b1;
            default: ;
        endcase
        push_raw(name, ph, ns, ew, wk, pd, dwell);
    endtask

    // Monitor
    int         dwell_cnt = 0;
    logic [10:0] last_out = 'x;
    logic [10:0] now_out;
    exp_t       cur;
    bit         have_cur = 1'b0;

    always @(posedge clk)
        if (rst === 1'b0 && tick === 1'b1) dwell_cnt++;

    always @(negedge clk) begin
        now_out = {phase, nsLight, ewLight, walk};
        if (now_out !== last_out) begin
            if (have_cur && cur.dwell >= 0) begin
                n_chk++;
                if (dwell_cnt == cur.dwell) n_pass++;
                else $display("FAIL dwell_%s: got %0d ticks, want %0d", cur.name, dwell_cnt, cur.dwell);
            end
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change: got phase=%0d ns=%b ew=%b walk=%b, want no change",
                         phase, nsLight, ewLight, walk);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                if ({phase, nsLight, ewLight, walk, pedPending} === {cur.ph, cur.ns, cur.ew, cur.wk, cur.pd})
                    n_pass++;
                else
                    $display("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b ped=%b, want phase=%0d ns=%b ew=%b walk=%b ped=%b",
                             cur.name, phase, nsLight, ewLight, walk, pedPending,
                             cur.ph, cur.ns, cur.ew, cur.wk, cur.pd);
            end
            last_out  = now_out;
            dwell_cnt = 0;
        end
    end

    // Stimulus helpers
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1; cycles(1);
        tick = 1'b0; cycles(1);
    endtask

    // Returns one clock after the DUT is seen in phase p.
    task automatic wait_phase(input logic [3:0] p);
        int k = 0;
        while (phase !== p && k < 300) begin
            cycles(1);
            k++;
        end
        if (phase !== p) begin
            n_chk++;
            $display("FAIL wait_phase: got phase=%0d, want %0d within 300 cycles", phase, p);
        end
        cycles(1);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mode = 2'b00;
        push("reset_redb", 5, 0, 2);

        // Day cycle with continuous tick
        push("day_nsg", 0, 0, 20);
        push("day_nsy", 1, 0, 3);
        push("day_reda", 2, 0, 2);
        push("day_ewg", 3, 0, 20);
        push("day_ewy", 4, 0, 3);
        push("day_redb", 5, 0, 2);
        push("day_nsg2", 0, 0, 20);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; tick = 1'b1;

        // Pedestrian pulse during NS_G
        if (LATCH) begin
            push("ped_nsy", 1, 1, 3);
            push("ped_reda", 2, 1, 2);
            push("ped_walk", 6, 0, 10);
            push("ped_ewg", 3, 0, -1);
        end else begin
            push("ped_nsy", 1, 0, 3);
            push("ped_reda", 2, 0, 2);
            push("ped_ewg", 3, 0, -1);
        end
        cycles(60);
        mode = 2'b10; cycles(1);
        mode = 2'b00;

        // Emergency mid EW_G with tick held low
        push("emg_ewy", 4, 0, 3);
        push("emg_hold", 7, 0, -1);
        push("emg_redb", 5, 0, 2);
        push("emg_nsg", 0, 0, 20);
        wait_phase(3);
        cycles(4);
        tick = 1'b0; mode = 2'b11;
        cycles(1);
        tick_pulse(); tick_pulse(); tick_pulse();
        wait_phase(7);
        tick_pulse();
        cycles(2);
        mode = 2'b00; tick = 1'b1;

        // Night flash
        push("night_nsy", 1, 0, 3);
        push("night_reda", 2, 0, 2);
        push_raw("flash_on1", 8, 3'b010, 3'b100, 0, 0, 1);
        push_raw("flash_off1", 8, 3'b000, 3'b000, 0, 0, 1);
        push_raw("flash_on2", 8, 3'b010, 3'b100, 0, 0, 1);
        push_raw("flash_off2", 8, 3'b000, 3'b000, 0, 0, 1);
        push("night_redb", 5, 0, 2);
        push("night_nsg", 0, 0, -1);
        wait_phase(0);
        mode = 2'b01;
        wait_phase(8);
        cycles(2);
        mode = 2'b00;

        // Emergency with a pending pedestrian request
        if (LATCH) begin
            push("ep_nsy", 1, 1, 3);
            push("ep_emg", 7, 1, -1);
            push("ep_redb", 5, 1, 2);
            push("ep_walk", 6, 0, 10);
            push("ep_nsg", 0, 0, 20);
        end else begin
            push("ep_nsy", 1, 0, 3);
            push("ep_emg", 7, 0, -1);
            push("ep_redb", 5, 0, 2);
            push("ep_nsg", 0, 0, 20);
        end
        wait_phase(0);
        mode = 2'b10; cycles(1);
        mode = 2'b11;
        wait_phase(7);
        cycles(2);
        mode = 2'b00;

        // Asynchronous reset in the middle of WALK
        push("rw_nsy", 1, 1, 3);
        push("rw_reda", 2, 1, 2);
        push("rw_walk", 6, LATCH ? 1'b0 : 1'b1, -1);
        push("rw_reset", 5, 0, 2);
        push("rw_nsg", 0, 0, -1);
        wait_phase(0);
        mode = 2'b10;
        wait_phase(6);
        cycles(2);
        @(posedge clk);
        #3 rst = 1'b1; mode = 2'b00;
        #3 rst = 1'b0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) cycles(1);
        cycles(3);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d expected entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
